// File: rtl/fixed_point_pkg.sv
// Shared constants and state encoding for the sequential fixed-point divider.
package fixed_point_pkg;

    // Default operand format: Q8.8 signed.
    localparam int WIDTH     = 16;
    localparam int FRAC_BITS = 8;

    // Number of restoring-division iterations (one quotient bit per cycle).
    localparam int ITER = WIDTH + FRAC_BITS;

    // Saturation limits of the default format.
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/fixed_point_divider_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_d_msb,
    input  logic [WIDTH-1:0] i_b_abs,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH+1:0] w_trial;
    logic [WIDTH+1:0] w_div;
    logic [WIDTH:0]   w_diff;

    // Trial subtraction. The remainder stays below |b| < 2^WIDTH, so the
    // shifted trial value always fits in WIDTH+1 bits when the subtraction
    // is taken.
    always_comb begin
        w_trial = {i_rem, i_d_msb};
        w_div   = {2'b00, i_b_abs};
        w_diff  = w_trial[WIDTH:0] - {1'b0, i_b_abs};
        o_q_bit = (w_trial >= w_div);
        o_rem   = o_q_bit ? w_diff : w_trial[WIDTH:0];
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: result = a / b, truncated toward
// zero, saturating on overflow and divide-by-zero. Fixed latency of
// WIDTH+FRAC_BITS+2 cycles from accept to the done pulse.
module fixed_point_divider #(
    parameter int WIDTH     = fixed_point_pkg::WIDTH,
    parameter int FRAC_BITS = fixed_point_pkg::FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag,
    output logic             negative,
    output logic             div_by_zero
);

    import fixed_point_pkg::*;

    localparam int N    = WIDTH + FRAC_BITS;
    localparam int CW   = $clog2(N + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(N - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    // Largest quotient magnitudes representable for each result sign.
    localparam logic [N-1:0]     Q_POS_LIM = {{FRAC_BITS{1'b0}}, MAX_VAL};
    localparam logic [N-1:0]     Q_NEG_LIM = {{FRAC_BITS{1'b0}}, MIN_VAL};

    state_t r_state;
    state_t r_state_next;

    logic             r_sign;
    logic             r_a_neg;
    logic             r_zero;
    logic [WIDTH-1:0] r_b_abs;
    logic [N-1:0]     r_d;
    logic [WIDTH:0]   r_rem;
    logic [N-1:0]     r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_fix_ph;
    logic             r_ovf_pend;

    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_dbz;
    logic             r_done;

    logic             w_busy;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_rem_next;
    logic             w_q_bit;
    logic             w_q_over;

    // The done cycle still counts as busy so a start there is ignored.
    assign w_busy   = (r_state != IDLE) || r_done;
    assign w_accept = start && !w_busy;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1).
    assign w_a_abs = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_b_abs = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Quotient magnitude exceeds what the signed result can hold.
    assign w_q_over = r_sign ? (r_q > Q_NEG_LIM) : (r_q > Q_POS_LIM);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem   (r_rem),
        .i_d_msb (r_d[N-1]),
        .i_b_abs (r_b_abs),
        .o_rem   (w_rem_next),
        .o_q_bit (w_q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN for N iterations -> FIX (two phases) -> IDLE.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    r_state_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    r_state_next = FIX;
                end
            end
            FIX: begin
                if (r_fix_ph) begin
                    r_state_next = IDLE;
                end
            end
            default: r_state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration registers and result fix-up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sign     <= 1'b0;
            r_a_neg    <= 1'b0;
            r_zero     <= 1'b0;
            r_b_abs    <= '0;
            r_d        <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_fix_ph   <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign   <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_a_neg  <= a[WIDTH-1];
                        r_zero   <= (b == '0);
                        r_b_abs  <= w_b_abs;
                        r_d      <= {w_a_abs, {FRAC_BITS{1'b0}}};
                        r_rem    <= '0;
                        r_q      <= '0;
                        r_cnt    <= '0;
                        r_fix_ph <= 1'b0;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[N-2:0], w_q_bit};
                    r_d   <= {r_d[N-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    if (!r_fix_ph) begin
                        // First phase: decide saturation.
                        r_ovf_pend <= w_q_over;
                        r_fix_ph   <= 1'b1;
                    end else begin
                        // Second phase: publish result and flags.
                        r_done <= 1'b1;
                        if (r_zero) begin
                            r_result <= r_a_neg ? MIN_VAL : MAX_VAL;
                            r_ovf    <= 1'b1;
                            r_dbz    <= 1'b1;
                        end else if (r_ovf_pend) begin
                            r_result <= r_sign ? MIN_VAL : MAX_VAL;
                            r_ovf    <= 1'b1;
                            r_dbz    <= 1'b0;
                        end else begin
                            r_result <= r_sign ? (~r_q[WIDTH-1:0] + 1'b1) : r_q[WIDTH-1:0];
                            r_ovf    <= 1'b0;
                            r_dbz    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_fix_ph <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = w_busy;
    assign done          = r_done;
    assign result        = r_result;
    assign overflow_flag = r_ovf;
    assign negative      = r_result[WIDTH-1];
    assign div_by_zero   = r_dbz;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider: table of vectors plus handshake
// and reset sequences.
module tb_fixed_point_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow_flag;
    logic        negative;
    logic        div_by_zero;

    int total;
    int bad;

    localparam int LAT = 26;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] exp_res;
        logic        exp_ovf;
        logic        exp_neg;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs [0:9];

    fixed_point_divider #(
        .WIDTH     (16),
        .FRAC_BITS (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .overflow_flag (overflow_flag),
        .negative      (negative),
        .div_by_zero   (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands and hold start across one rising edge (the accept edge).
    task automatic launch(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after acceptance until done is seen; 60 means timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFF00, 16'h0400, 16'hFFC0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h6400, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h0500, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'hFB00, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{16'h0000, 16'hFD00, 16'h0000, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", {29'd0, overflow_flag, negative, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].va, vecs[i].vb);
            chk($sformatf("v%0d_busy_after_accept", i), 32'(busy), 32'd1);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
            chk($sformatf("v%0d_ovf", i), 32'(overflow_flag), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_neg", i), 32'(negative), 32'(vecs[i].exp_neg));
            chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].exp_dbz));
            chk($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd1);
            $display("vec %0d: %h / %h -> %h ovf=%0d neg=%0d dbz=%0d lat=%0d",
                     i, vecs[i].va, vecs[i].vb, result, overflow_flag, negative, div_by_zero, lat);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
        end

        // Handshake: operand changes and start pulses while busy are ignored.
        launch(16'h0300, 16'h0200);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) begin
                a = 16'h7000;
                b = 16'h0100;
            end
            if (lat == 4) begin
                a = 16'h0100;
                b = 16'h0300;
                start = 1'b1;
            end
            if (lat == 5) start = 1'b0;
            if (done) break;
        end
        chk("hs_latency", 32'(lat), 32'(LAT));
        chk("hs_result", 32'(result), 32'h0180);
        // Start raised during the done cycle: must be ignored.
        a = 16'hFF00;
        b = 16'h0400;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_ignored_in_done", 32'(busy), 32'd0);
        chk("hs_result_held", 32'(result), 32'h0180);
        // Start still high in the following cycle: accepted.
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hs_second_accept", 32'(busy), 32'd1);
        chk("hs_result_not_cleared", 32'(result), 32'h0180);
        wait_done(lat);
        chk("hs2_latency", 32'(lat), 32'(LAT));
        chk("hs2_result", 32'(result), 32'hFFC0);
        $display("handshake: second result %h lat=%0d", result, lat);

        // Reset in the middle of RUN aborts without a done pulse.
        launch(16'h0100, 16'h0300);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", {29'd0, overflow_flag, negative, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("rst_no_done", 32'(pulses), 32'd0);
        launch(16'hFF00, 16'h0300);
        wait_done(lat);
        chk("post_rst_latency", 32'(lat), 32'(LAT));
        chk("post_rst_result", 32'(result), 32'hFFAB);
        chk("post_rst_neg", 32'(negative), 32'd1);
        $display("after reset: result %h lat=%0d", result, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
